serial_bit_feeder: RTL
======================

SERIAL_BIT_FEEDER -- requirements
Module: serial_bit_feeder

Interface
REQ-001 Parameter WIDTH, default 8: number of bits per loaded word (2..16).
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift out MSB first, 0 = shift out LSB first.
REQ-003 Parameter IDLE_LEVEL, default 1'b0: bit_out level driven whenever no word is being shifted.
REQ-004 clk_pulse  input  1  sole clock; all state updates on its rising edge.
REQ-005 clear  input  1  reset, synchronous and active-high.
REQ-006 load_data  input  WIDTH  parallel word to serialize.
REQ-007 load_valid  input  1  load_data is valid this cycle.
REQ-008 load_ready  output  1  block accepts a word this cycle.
REQ-009 bit_out  output  1  serial bit stream; feeds the pattern detector's serial input directly.
REQ-010 bit_valid  output  1  high while bit_out carries a data bit.
REQ-011 frame_done  output  1  one-cycle pulse after the last bit of a word.
REQ-012 words_sent  output  8  count of completed words, wraps modulo 256.

Function
REQ-013 States SHALL be IDLE and SHIFT, held in a registered state variable.
REQ-014 A transfer SHALL occur on a rising edge where load_valid=1 and load_ready=1.
REQ-015 load_ready SHALL be 1 in IDLE, and 1 in SHIFT only when bit_index = WIDTH-1; otherwise 0.
REQ-016 On a transfer, the next cycle SHALL be SHIFT with bit_index=0, and bit_out SHALL present the first bit (MSB if MSB_FIRST=1, else LSB).
REQ-017 In SHIFT, each cycle SHALL present exactly one bit, with bit_valid=1; bit_index SHALL increment every edge.
REQ-018 Latency: the first bit SHALL appear 1 cycle after the transfer edge; the word SHALL occupy exactly WIDTH consecutive cycles.
REQ-019 At the edge where bit_index=WIDTH-1:
- With a simultaneous transfer, the state SHALL stay SHIFT with bit_index=0 and the new word loaded (back-to-back, no gap cycle).
- Otherwise, the state SHALL return to IDLE.
REQ-020 In IDLE, bit_out SHALL equal IDLE_LEVEL and bit_valid SHALL be 0.
REQ-021 load_valid while load_ready=0 SHALL be ignored; the in-flight word SHALL NOT be disturbed.
REQ-022 frame_done SHALL be 1 for exactly the cycle after each word's last bit, including back-to-back words.
REQ-023 words_sent SHALL increment on each last-bit edge and wrap 255 -> 0.
REQ-024 bit_out, bit_valid, frame_done and words_sent SHALL be functions of registers only, with no combinational path from any input.
REQ-025 load_ready SHALL depend only on state and bit_index.

Reset
REQ-026 clear=1 at a rising edge SHALL force all of the following, regardless of other inputs:
- state IDLE, bit_index 0, shift register 0;
- bit_out=IDLE_LEVEL, bit_valid=0, frame_done=0, words_sent=0.
REQ-027 clear asserted mid-word SHALL abandon the word with no frame_done and no words_sent increment.
REQ-028 A transfer SHALL be accepted on the first edge after clear deasserts.

Structure
REQ-029 State encodings (IDLE, SHIFT) and the default WIDTH constant SHALL live in a shared fsm package used by the detector family.
REQ-030 The block SHALL be one module, with no sub-module; shift register, bit counter, FSM and word counter are inline.

Verification
REQ-031 MSB_FIRST=1, load 8'b11011011 -> bit_out 1,1,0,1,1,0,1,1 on cycles 1-8 after transfer; frame_done on cycle 9; words_sent=1.
REQ-032 Back-to-back: 8'hDB then 8'hFF with load_valid held -> 16 consecutive bit_valid cycles, no gap; two frame_done pulses 8 cycles apart; words_sent=2.
REQ-033 clear at bit_index=3 of 8'hDB -> next cycle IDLE, bit_out=0, bit_valid=0, words_sent unchanged at 0, no frame_done.
REQ-034 MSB_FIRST=0, load 8'b00011011 -> bit_out 1,1,0,1,1,0,0,0; chained into the detector, its out asserts after bit 5.
REQ-035 load_valid pulsed at bit_index=2 with 8'h00 -> ignored; the current word completes unchanged; load_ready=0 that cycle.
REQ-036 256 back-to-back words -> words_sent wraps 255 -> 0 on the 256th last-bit edge.

Source files
------------

// File: rtl/serial_bit_feeder_pkg.sv
// Shared FSM definitions for the serial feeder / pattern detector family.
//   state_t       : two-state controller encoding (IDLE, SHIFT)
//   DEFAULT_WIDTH : default parallel word width of the family
package serial_bit_feeder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage : serial_bit_feeder_pkg

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial word feeder. Accepts a WIDTH-bit word through a
// valid/ready handshake and presents it one bit per cycle on bit_out,
// back-to-back with no gap cycle when a new word is offered on the last bit.
//
// Ports:
//   clk_pulse   in   rising-edge clock for all state
//   clear       in   synchronous active-high reset
//   load_data   in   [WIDTH-1:0] word to serialize
//   load_valid  in   load_data is valid this cycle
//   load_ready  out  a word is accepted this cycle (state/bit_index only)
//   bit_out     out  registered serial bit, IDLE_LEVEL when not shifting
//   bit_valid   out  registered, high while bit_out carries a data bit
//   frame_done  out  registered one-cycle pulse after each word's last bit
//   words_sent  out  [7:0] completed-word count, wraps modulo 256
module serial_bit_feeder
  import serial_bit_feeder_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk_pulse,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_done,
  output logic [7:0]       words_sent
);

  localparam int               IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state;
  logic [IDX_W-1:0] bit_index;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_adv;
  logic             last_bit;
  logic             transfer;

  // Bit presented first from a word, according to the shift direction.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word with the already-presented bit shifted out.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // The cycle in which the final bit of the word is on bit_out.
  assign last_bit   = (state == SHIFT) && (bit_index == LAST_IDX);
  assign load_ready = (state == IDLE) || last_bit;
  assign transfer   = load_valid && load_ready;
  assign shreg_adv  = advance(shreg);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_pulse) begin
    if (clear) begin
      // NOTE: the shift register is datapath storage, but it is cleared too
      // so an abandoned word can never leak into a later frame.
      state      <= IDLE;
      bit_index  <= '0;
      shreg      <= '0;
      bit_out    <= IDLE_LEVEL;
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
      words_sent <= 8'd0;
    end else begin
      frame_done <= last_bit;
      if (last_bit) words_sent <= words_sent + 8'd1;

      if (transfer) begin
        // New word: first bit goes straight to the output register so it
        // appears one cycle after the accepting edge.
        state     <= SHIFT;
        bit_index <= '0;
        shreg     <= load_data;
        bit_out   <= first_bit(load_data);
        bit_valid <= 1'b1;
      end else if ((state == SHIFT) && !last_bit) begin
        bit_index <= bit_index + IDX_W'(1);
        shreg     <= shreg_adv;
        bit_out   <= first_bit(shreg_adv);
        bit_valid <= 1'b1;
      end else begin
        state     <= IDLE;
        bit_index <= '0;
        shreg     <= '0;
        bit_out   <= IDLE_LEVEL;
        bit_valid <= 1'b0;
      end
    end
  end

endmodule : serial_bit_feeder
